// File: rtl/dm_cache_controller.sv
// Direct-mapped, read-allocate data cache: 1024 lines x 4 words, filled from main memory on a miss.
// Hit and miss statistics use saturating counters.
module dm_cache_controller #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 2,
  parameter int CNT_W    = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cache_read,
  input  logic                       cache_write,
  input  logic [ADDR_W-1:0]          address,
  output logic                       cache_ready,
  output logic [DATA_W-1:0]          cache_rdata,
  output logic                       mem_read,
  output logic [ADDR_W-OFFSET_W-1:0] mem_addr,
  input  logic                       mem_ready,
  input  logic [4*DATA_W-1:0]        mem_rdata,
  output logic [CNT_W-1:0]           hit_count,
  output logic [CNT_W-1:0]           miss_count
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int BLK_W = 4 * DATA_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESPOND} state_t;

  state_t                   state_r;
  logic [ADDR_W-1:0]        addr_r;
  logic [LINES-1:0]         valid_r;
  logic [TAG_W-1:0]         tag_mem_r  [LINES];
  logic [BLK_W-1:0]         data_mem_r [LINES];

  logic [INDEX_W-1:0]       idx_s;
  logic [TAG_W-1:0]         tag_s;
  logic [OFFSET_W-1:0]      off_s;
  logic [BLK_W-1:0]         line_s;
  logic                     hit_s;
  logic                     fill_s;
  logic                     unused_s;

  function automatic logic [DATA_W-1:0] select_word(input logic [BLK_W-1:0] blk,
                                                    input logic [OFFSET_W-1:0] off);
    return blk[DATA_W*off +: DATA_W];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == {CNT_W{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign idx_s    = addr_r[OFFSET_W +: INDEX_W];
  assign tag_s    = addr_r[ADDR_W-1 -: TAG_W];
  assign off_s    = addr_r[OFFSET_W-1:0];
  assign line_s   = data_mem_r[idx_s];
  assign hit_s    = valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);
  assign fill_s   = (state_r == FILL) && mem_ready;
  // The cache is read-only; write requests are deliberately dropped.
  assign unused_s = cache_write;

  // Valid bits: cleared asynchronously by reset, set when a line is filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
    end else if (fill_s) begin
      valid_r[idx_s] <= 1'b1;
    end
  end

  // Tag and data arrays are not reset; a stale line is harmless while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_mem_r[idx_s]  <= tag_s;
      data_mem_r[idx_s] <= mem_rdata;
    end
  end

  // Controller FSM with registered handshake, data and statistics outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      cache_ready <= 1'b0;
      cache_rdata <= '0;
      mem_read    <= 1'b0;
      mem_addr    <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      cache_ready <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cache_read) begin
            addr_r  <= address;
            state_r <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            cache_rdata <= select_word(line_s, off_s);
            hit_count   <= sat_inc(hit_count);
            cache_ready <= 1'b1;
            state_r     <= RESPOND;
          end else begin
            mem_read <= 1'b1;
            mem_addr <= addr_r[ADDR_W-1:OFFSET_W];
            state_r  <= FILL;
          end
        end
        FILL: begin
          if (mem_ready) begin
            cache_rdata <= select_word(mem_rdata, off_s);
            miss_count  <= sat_inc(miss_count);
            mem_read    <= 1'b0;
            cache_ready <= 1'b1;
            state_r     <= RESPOND;
          end
        end
        // The extra IDLE cycle after RESPOND lets the CPU present its next address first.
        RESPOND: begin
          state_r <= IDLE;
        end
        default: begin
          mem_read <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Self-checking bench for dm_cache_controller: directed scenarios plus randomized reads
// checked against a table-based cache model and a synthetic memory image.
module tb_dm_cache_controller;

  logic         clk;
  logic         rst;
  logic         cache_read;
  logic         cache_write;
  logic [14:0]  address;
  logic         cache_ready;
  logic [31:0]  cache_rdata;
  logic         mem_read;
  logic [12:0]  mem_addr;
  logic         mem_ready;
  logic [127:0] mem_rdata;
  logic [13:0]  hit_count;
  logic [13:0]  miss_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_resp  = 0;
  bit drop_mode = 1'b0;

  // Reference model: one valid flag and tag per line, plus expected counters.
  bit         m_valid [1024];
  logic [2:0] m_tag   [1024];
  int         m_hits;
  int         m_misses;

  dm_cache_controller dut (
    .clk         (clk),
    .rst         (rst),
    .cache_read  (cache_read),
    .cache_write (cache_write),
    .address     (address),
    .cache_ready (cache_ready),
    .cache_rdata (cache_rdata),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [14:0] a);
    return {2'b10, a, a} ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [127:0] mem_block(input logic [12:0] b);
    logic [127:0] blk;
    for (int w = 0; w < 4; w++) blk[32*w +: 32] = mem_word({b, 2'(w)});
    return blk;
  endfunction

  function automatic void model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    cache_read = 1'b0;
    mem_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    check_eq("rst_ready", cache_ready, 1'b0);
    check_eq("rst_memread", mem_read, 1'b0);
    check_eq("rst_rdata", cache_rdata, 32'h0);
    check_eq("rst_memaddr", mem_addr, 13'h0);
    check_eq("rst_hits", hit_count, 14'h0);
    check_eq("rst_misses", miss_count, 14'h0);
  endtask

  // One CPU read, started at a negedge with the DUT idle. With keep set, the CPU
  // presents nxt while still requesting, as a back-to-back CPU would.
  task automatic do_read(input logic [14:0] a, input int dly, input bit keep, input logic [14:0] nxt);
    bit          exp_hit;
    bit          done;
    bit          fetched;
    bit          stable;
    int          k;
    int          held;
    logic [12:0] ma;
    exp_hit     = m_valid[a[11:2]] && (m_tag[a[11:2]] == a[14:12]);
    address     = a;
    cache_read  = 1'b1;
    cache_write = 1'($urandom_range(0, 1));
    k = 0; held = 0; done = 1'b0; fetched = 1'b0; stable = 1'b1; ma = '0;
    while (!done && k < 100) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      mem_ready = 1'b0;
      if (k == 1 && drop_mode) cache_read = 1'b0;
      if (cache_ready) begin
        done = 1'b1;
      end else if (mem_read) begin
        if (!fetched) begin
          fetched = 1'b1;
          ma      = mem_addr;
        end else if (mem_addr != ma) begin
          stable = 1'b0;
        end
        if (held < dly) begin
          held++;
        end else begin
          mem_ready = 1'b1;
          mem_rdata = mem_block(mem_addr);
        end
      end
    end
    if (done) n_resp++;
    check_eq("completed", done, 1'b1);
    check_eq("latency", k, exp_hit ? 2 : 3 + dly);
    check_eq("missed", fetched, !exp_hit);
    if (fetched) begin
      check_eq("mem_addr", ma, a[14:2]);
      check_eq("mem_stable", stable, 1'b1);
    end
    check_eq("rdata", cache_rdata, mem_word(a));
    check_eq("mem_drop", mem_read, 1'b0);
    if (exp_hit) begin
      if (m_hits < 16383) m_hits++;
    end else begin
      if (m_misses < 16383) m_misses++;
      m_valid[a[11:2]] = 1'b1;
      m_tag[a[11:2]]   = a[14:12];
    end
    if (keep) begin
      address    = nxt;
      cache_read = 1'b1;
    end else begin
      cache_read = 1'b0;
    end
    @(negedge clk);
    check_eq("ready_pulse", cache_ready, 1'b0);
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_hits"}, hit_count, 14'(m_hits));
    check_eq({tag, "_misses"}, miss_count, 14'(m_misses));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] addrs [400];
    logic [13:0] hits_before;
    logic [13:0] miss_before;
    int          resp_before;
    int          k;
    bit          bad;

    rst = 1'b1; cache_read = 1'b0; cache_write = 1'b0; address = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    do_reset();

    // Block at 1024: one miss then three hits.
    for (int i = 0; i < 4; i++) do_read(15'(1024 + i), 0, 1'b0, 15'h0);
    check_eq("seq4_hits", hit_count, 14'd3);
    check_eq("seq4_misses", miss_count, 14'd1);

    // Conflicting tags on index 0.
    miss_before = miss_count;
    do_read(15'h0000, 1, 1'b0, 15'h0);
    do_read(15'h1000, 2, 1'b0, 15'h0);
    do_read(15'h0000, 0, 1'b0, 15'h0);
    check_eq("conflict_misses", miss_count - miss_before, 14'd3);
    check_counts("conflict");

    // Slow memory and the maximum address.
    do_read(15'h7FFF, 5, 1'b0, 15'h0);
    do_read(15'h7FFC, 0, 1'b0, 15'h0);
    check_counts("slow");

    // Write requests alone must not start anything.
    hits_before = hit_count;
    miss_before = miss_count;
    bad = 1'b0;
    cache_read  = 1'b0;
    cache_write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_read || cache_ready) bad = 1'b1;
    end
    cache_write = 1'b0;
    check_eq("write_ignored", bad, 1'b0);
    check_eq("write_hits", hit_count, hits_before);
    check_eq("write_misses", miss_count, miss_before);
    do_read(15'h0001, 0, 1'b0, 15'h0);

    // Reset in the middle of a fill.
    do_reset();
    @(negedge clk);
    address = 15'h2345;
    cache_read = 1'b1;
    k = 0;
    while (!mem_read && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("midfill_req", mem_read, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("midfill_drop", mem_read, 1'b0);
    check_eq("midfill_hits", hit_count, 14'h0);
    check_eq("midfill_misses", miss_count, 14'h0);
    cache_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    do_read(15'h2345, 1, 1'b0, 15'h0);
    check_counts("reread");

    // Randomized reads over a small set of lines and all tags.
    for (int i = 0; i < 400; i++) begin
      addrs[i] = 15'($urandom_range(0, 32767)) & 15'h700F;
      if ($urandom_range(0, 9) == 0) addrs[i] = 15'h7FFF;
    end
    for (int i = 0; i < 400; i++) begin
      drop_mode = ($urandom_range(0, 3) == 0);
      do_read(addrs[i], int'($urandom_range(0, 3)), (i < 399) ? 1'($urandom_range(0, 1)) : 1'b0,
              (i < 399) ? addrs[i+1] : 15'h0);
    end
    drop_mode = 1'b0;
    check_counts("random");

    // Full sequential run with back-to-back requests.
    do_reset();
    resp_before = n_resp;
    for (int i = 0; i < 8192; i++) begin
      do_read(15'(1024 + i), int'($urandom_range(0, 1)), (i < 8191), 15'(1025 + i));
    end
    check_eq("run_pulses", n_resp - resp_before, 8192);
    check_eq("run_hits", hit_count, 14'd6144);
    check_eq("run_misses", miss_count, 14'd2048);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
